router_fifo: RTL and testbench

Per-destination output buffer of the router. It sits directly downstream of the register stage and captures each byte that stage drives onto its `dout` bus, together with a header tag. It holds up to DEPTH bytes and returns them in order to the destination's read port. It tracks packet boundaries on the read side from the header length field, and supports a soft reset that flushes the buffer when a destination times out.

---
 rtl/router_fifo_pkg.sv | 24 ++
 rtl/router_fifo_if.sv | 43 ++++
 rtl/router_fifo.sv | 91 +++++++++
 tb/tb_router_fifo.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/router_fifo_pkg.sv
// Shared router definitions: data width, buffer depth, header field layout and
// the buffered word format {hdr_tag, byte}.
package router_fifo_pkg;

  localparam int unsigned ROUTER_DATA_W     = 8;
  localparam int unsigned ROUTER_FIFO_DEPTH = 16;

  // Header byte layout: destination address in [1:0], payload length in [7:2].
  localparam int unsigned HDR_ADDR_LSB = 0;
  localparam int unsigned HDR_ADDR_MSB = 1;
  localparam int unsigned HDR_LEN_LSB  = 2;
  localparam int unsigned HDR_LEN_MSB  = 7;

  typedef struct packed {
    logic                     hdr_tag;
    logic [ROUTER_DATA_W-1:0] data;
  } fifo_word_t;

  // Bytes still to come after a header: payload length plus the parity byte.
  function automatic logic [6:0] hdr_remaining(input logic [ROUTER_DATA_W-1:0] hdr);
    return {1'b0, hdr[HDR_LEN_MSB:HDR_LEN_LSB]} + 7'd1;
  endfunction

endpackage

// File: rtl/router_fifo_if.sv
// Handshake bundle between the register stage / destination port (master) and
// the per-destination output buffer (slave).
interface router_fifo_if
  import router_fifo_pkg::*;
#(
  parameter int unsigned WIDTH = ROUTER_DATA_W
);

  logic             soft_reset;
  logic             write_enb;
  logic             read_enb;
  logic             lfd_state;
  logic [WIDTH-1:0] data_in;
  logic             full;
  logic             empty;
  logic             pkt_rd_busy;
  logic [WIDTH-1:0] data_out;

  modport master (
    output soft_reset,
    output write_enb,
    output read_enb,
    output lfd_state,
    output data_in,
    input  full,
    input  empty,
    input  pkt_rd_busy,
    input  data_out
  );

  modport slave (
    input  soft_reset,
    input  write_enb,
    input  read_enb,
    input  lfd_state,
    input  data_in,
    output full,
    output empty,
    output pkt_rd_busy,
    output data_out
  );

endinterface

// File: rtl/router_fifo.sv
// Per-destination output buffer: in-order byte FIFO with header tags, read-side
// packet tracking and a synchronous flush for destination timeouts.
module router_fifo
  import router_fifo_pkg::*;
#(
  parameter int unsigned DEPTH = ROUTER_FIFO_DEPTH,
  parameter int unsigned WIDTH = ROUTER_DATA_W
) (
  input  logic           clock,
  input  logic           resetn,
  router_fifo_if.slave   bus
);

  localparam int unsigned AW = $clog2(DEPTH);

  localparam logic [AW:0]   FullCount = (AW + 1)'(DEPTH);
  localparam logic [AW:0]   CntOne    = {{AW{1'b0}}, 1'b1};
  localparam logic [AW-1:0] PtrOne    = {{(AW - 1){1'b0}}, 1'b1};

  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic [6:0]       rem_q;
  logic [WIDTH-1:0] data_out_q;
  logic [WIDTH:0]   mem [DEPTH];

  logic             full;
  logic             empty;
  logic             flush;
  logic             wr_acc;
  logic             rd_acc;
  logic [WIDTH:0]   rd_word;

  assign full  = (count_q == FullCount);
  assign empty = (count_q == '0);
  assign flush = !resetn || bus.soft_reset;

  // Accepts are judged on the pre-edge flags; a flush cycle swallows both sides.
  assign wr_acc = bus.write_enb && !full  && !flush;
  assign rd_acc = bus.read_enb  && !empty && !flush;

  assign rd_word = mem[rd_ptr_q];

  // Storage is not reset; the pointers define which entries are live.
  always_ff @(posedge clock) begin
    if (wr_acc) begin
      mem[wr_ptr_q] <= {bus.lfd_state, bus.data_in};
    end
  end

  always_ff @(posedge clock) begin
    if (flush) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      rem_q      <= '0;
      data_out_q <= '0;
    end else begin
      if (wr_acc) begin
        wr_ptr_q <= wr_ptr_q + PtrOne;
      end
      if (rd_acc) begin
        rd_ptr_q   <= rd_ptr_q + PtrOne;
        data_out_q <= rd_word[WIDTH-1:0];
        if (rd_word[WIDTH]) begin
          rem_q <= hdr_remaining(rd_word[WIDTH-1:0]);
        end else if (rem_q != '0) begin
          rem_q <= rem_q - 7'd1;
        end
      end
      case ({wr_acc, rd_acc})
        2'b10:   count_q <= count_q + CntOne;
        2'b01:   count_q <= count_q - CntOne;
        default: count_q <= count_q;
      endcase
    end
  end

  assign bus.full        = full;
  assign bus.empty       = empty;
  assign bus.pkt_rd_busy = (rem_q != '0);
  assign bus.data_out    = data_out_q;

`ifndef SYNTHESIS
  a_no_overflow: assert property (@(posedge clock) disable iff (!resetn)
    count_q <= FullCount);
  a_flags_exclusive: assert property (@(posedge clock) disable iff (!resetn)
    !(full && empty));
`endif

endmodule

// File: tb/tb_router_fifo.sv
// Directed self-checking bench for router_fifo: reset, packet ordering, full
// boundary, streaming, wrap-around, empty read and soft reset mid-packet.
module tb_router_fifo;

  logic clk;
  logic resetn;
  int   checks;
  int   failures;

  router_fifo_if #(.WIDTH(8)) bus ();

  router_fifo #(
    .DEPTH(16),
    .WIDTH(8)
  ) dut (
    .clock (clk),
    .resetn(resetn),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.soft_reset = 1'b0;
    bus.write_enb  = 1'b0;
    bus.read_enb   = 1'b0;
    bus.lfd_state  = 1'b0;
    bus.data_in    = 8'h00;
  endtask

  task automatic push(input logic [7:0] d, input logic tag);
    bus.write_enb = 1'b1;
    bus.lfd_state = tag;
    bus.data_in   = d;
    tick();
    bus.write_enb = 1'b0;
    bus.lfd_state = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    resetn = 1'b0;
    tick();
    tick();
    resetn = 1'b1;
    checks++;
    if (bus.empty !== 1'b1) begin
      failures++;
      $display("FAIL reset_empty got=%b want=1", bus.empty);
    end
    checks++;
    if (bus.full !== 1'b0) begin
      failures++;
      $display("FAIL reset_full got=%b want=0", bus.full);
    end
    checks++;
    if (bus.pkt_rd_busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_busy got=%b want=0", bus.pkt_rd_busy);
    end
    checks++;
    if (bus.data_out !== 8'h00) begin
      failures++;
      $display("FAIL reset_data got=%h want=00", bus.data_out);
    end
  endtask

  task automatic test_packet();
    logic [7:0] exp_d [5];
    logic [6:0] exp_rem [5];
    exp_d   = '{8'h0D, 8'h11, 8'h22, 8'h33, 8'h3F};
    exp_rem = '{7'd4, 7'd3, 7'd2, 7'd1, 7'd0};
    push(8'h0D, 1'b1);
    checks++;
    if (bus.empty !== 1'b0) begin
      failures++;
      $display("FAIL pkt_empty_after_write got=%b want=0", bus.empty);
    end
    push(8'h11, 1'b0);
    push(8'h22, 1'b0);
    push(8'h33, 1'b0);
    push(8'h3F, 1'b0);
    bus.read_enb = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (bus.data_out !== exp_d[i]) begin
        failures++;
        $display("FAIL pkt_data[%0d] got=%h want=%h", i, bus.data_out, exp_d[i]);
      end
      checks++;
      if (dut.rem_q !== exp_rem[i]) begin
        failures++;
        $display("FAIL pkt_rem[%0d] got=%0d want=%0d", i, dut.rem_q, exp_rem[i]);
      end
      checks++;
      if (bus.pkt_rd_busy !== (i < 4)) begin
        failures++;
        $display("FAIL pkt_busy[%0d] got=%b want=%b", i, bus.pkt_rd_busy, (i < 4));
      end
    end
    bus.read_enb = 1'b0;
    checks++;
    if (bus.empty !== 1'b1) begin
      failures++;
      $display("FAIL pkt_empty_end got=%b want=1", bus.empty);
    end
  endtask

  task automatic test_full();
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (bus.full !== 1'b0) begin
        failures++;
        $display("FAIL full_early[%0d] got=%b want=0", i, bus.full);
      end
      push(8'(i), 1'b0);
    end
    checks++;
    if (bus.full !== 1'b1) begin
      failures++;
      $display("FAIL full_after16 got=%b want=1", bus.full);
    end
    push(8'hAA, 1'b0);
    checks++;
    if (bus.full !== 1'b1) begin
      failures++;
      $display("FAIL full_after17 got=%b want=1", bus.full);
    end
    // Concurrent read and write while full: only the read goes through.
    bus.write_enb = 1'b1;
    bus.data_in   = 8'hBB;
    bus.read_enb  = 1'b1;
    tick();
    bus.write_enb = 1'b0;
    checks++;
    if (bus.data_out !== 8'h00 || bus.full !== 1'b0) begin
      failures++;
      $display("FAIL full_rw got data=%h full=%b want data=00 full=0", bus.data_out, bus.full);
    end
    for (int i = 1; i < 16; i++) begin
      tick();
      checks++;
      if (bus.data_out !== 8'(i)) begin
        failures++;
        $display("FAIL full_drain[%0d] got=%h want=%h", i, bus.data_out, 8'(i));
      end
    end
    bus.read_enb = 1'b0;
    checks++;
    if (bus.empty !== 1'b1) begin
      failures++;
      $display("FAIL full_drain_empty got=%b want=1 (AA/BB not dropped?)", bus.empty);
    end
  endtask

  task automatic test_back_to_back();
    push(8'hA0, 1'b0);
    bus.write_enb = 1'b1;
    bus.read_enb  = 1'b1;
    for (int i = 1; i < 5; i++) begin
      bus.data_in = 8'hA0 + 8'(i);
      tick();
      checks++;
      if (bus.data_out !== 8'hA0 + 8'(i - 1)) begin
        failures++;
        $display("FAIL b2b[%0d] got=%h want=%h", i, bus.data_out, 8'hA0 + 8'(i - 1));
      end
    end
    bus.write_enb = 1'b0;
    tick();
    bus.read_enb = 1'b0;
    checks++;
    if (bus.data_out !== 8'hA4 || bus.empty !== 1'b1) begin
      failures++;
      $display("FAIL b2b_last got data=%h empty=%b want data=a4 empty=1",
               bus.data_out, bus.empty);
    end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 12; i++) push(8'h40 + 8'(i), 1'b0);
    bus.read_enb = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      checks++;
      if (bus.data_out !== 8'h40 + 8'(i)) begin
        failures++;
        $display("FAIL wrap_pre[%0d] got=%h want=%h", i, bus.data_out, 8'h40 + 8'(i));
      end
    end
    bus.read_enb = 1'b0;
    for (int i = 0; i < 8; i++) push(8'h50 + 8'(i), 1'b0);
    bus.read_enb = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++;
      if (bus.data_out !== 8'h50 + 8'(i)) begin
        failures++;
        $display("FAIL wrap[%0d] got=%h want=%h", i, bus.data_out, 8'h50 + 8'(i));
      end
    end
    bus.read_enb = 1'b0;
    checks++;
    if (bus.empty !== 1'b1) begin
      failures++;
      $display("FAIL wrap_empty got=%b want=1", bus.empty);
    end
  endtask

  task automatic test_empty_read();
    bus.read_enb = 1'b1;
    tick();
    tick();
    bus.read_enb = 1'b0;
    checks++;
    if (bus.data_out !== 8'h57 || bus.empty !== 1'b1) begin
      failures++;
      $display("FAIL empty_read got data=%h empty=%b want data=57 empty=1",
               bus.data_out, bus.empty);
    end
    // One write must bring occupancy to exactly 1, not past an underflow.
    push(8'h66, 1'b0);
    bus.read_enb = 1'b1;
    tick();
    bus.read_enb = 1'b0;
    checks++;
    if (bus.data_out !== 8'h66 || bus.empty !== 1'b1) begin
      failures++;
      $display("FAIL empty_read_count got data=%h empty=%b want data=66 empty=1",
               bus.data_out, bus.empty);
    end
  endtask

  task automatic test_soft_reset();
    push(8'h0D, 1'b1);
    push(8'h11, 1'b0);
    push(8'h22, 1'b0);
    push(8'h33, 1'b0);
    push(8'h3F, 1'b0);
    bus.read_enb = 1'b1;
    tick();
    tick();
    bus.read_enb = 1'b0;
    checks++;
    if (bus.pkt_rd_busy !== 1'b1 || bus.data_out !== 8'h11) begin
      failures++;
      $display("FAIL sr_pre got busy=%b data=%h want busy=1 data=11",
               bus.pkt_rd_busy, bus.data_out);
    end
    bus.soft_reset = 1'b1;
    bus.write_enb  = 1'b1;
    bus.data_in    = 8'h77;
    bus.read_enb   = 1'b1;
    tick();
    idle();
    checks++;
    if (bus.empty !== 1'b1 || bus.full !== 1'b0) begin
      failures++;
      $display("FAIL sr_flags got empty=%b full=%b want empty=1 full=0", bus.empty, bus.full);
    end
    checks++;
    if (bus.pkt_rd_busy !== 1'b0) begin
      failures++;
      $display("FAIL sr_busy got=%b want=0", bus.pkt_rd_busy);
    end
    checks++;
    if (bus.data_out !== 8'h00) begin
      failures++;
      $display("FAIL sr_data got=%h want=00", bus.data_out);
    end
    push(8'h99, 1'b0);
    bus.read_enb = 1'b1;
    tick();
    bus.read_enb = 1'b0;
    checks++;
    if (bus.data_out !== 8'h99 || bus.empty !== 1'b1 || bus.pkt_rd_busy !== 1'b0) begin
      failures++;
      $display("FAIL sr_next got data=%h empty=%b busy=%b want data=99 empty=1 busy=0",
               bus.data_out, bus.empty, bus.pkt_rd_busy);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    resetn   = 1'b0;
    idle();
    test_reset();
    test_packet();
    test_full();
    test_back_to_back();
    test_wrap();
    test_empty_read();
    test_soft_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
